// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: an 8-entry byte FIFO shared by NREQ write requesters.
// A round-robin arbiter grants one requester per cycle. A single consumer
// drains the FIFO through ren.
// Optional feature: define FIFO_ARB_DROPCNT_EN to add the drop_cnt output.
// drop_cnt is a saturating 8-bit count of cycles in which a request stalled.
//
// Handshake: req[i] is a level "valid" that the requester holds, together
// with its din slice, until it sees gnt[i]. gnt is the combinational "ready"
// for that requester. The byte is written on the rising edge where
// req[i] && gnt[i]. The FIFO does not back-pressure the reader: ren while
// empty is flagged on error and changes no read-side state.
module fifo_wr_arbiter #(
    parameter int NREQ  = 4,
    parameter int DW    = 8,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*DW-1:0] din,
    output logic [NREQ-1:0]   gnt,
    input  logic              ren,
    output logic [DW-1:0]     dout,
    output logic              dout_valid,
    output logic [AW:0]       count,
    output logic              full,
    output logic              empty,
    output logic              error
`ifdef FIFO_ARB_DROPCNT_EN
    ,
    output logic [7:0]        drop_cnt
`endif
);

    localparam int RW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [RW-1:0] LAST_REQ = RW'(NREQ - 1);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] waddr;
    logic [AW-1:0] raddr;
    logic [RW-1:0] rr;
    logic [RW-1:0] gnt_idx;
    logic [RW-1:0] rr_next;
    logic [RW-1:0] cand_idx;
    logic          acc;
    logic          wr;
    logic          rd;
    logic          found;
    int            cand;

    // A write can be accepted when there is room, or when a read frees a
    // slot on the same edge. Nothing is granted while reset is held.
    always_comb begin
        acc = 1'b0;
        if (rst_n && (|req) && ((count < DEPTH_C) || (ren && (count != '0))))
            acc = 1'b1;
    end

    // Round-robin search: the first set req at or after rr, wrapping mod NREQ.
    always_comb begin
        gnt      = '0;
        gnt_idx  = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = int'(rr) + k;
            if (cand >= NREQ)
                cand = cand - NREQ;
            cand_idx = RW'(cand);
            if (acc && !found && req[cand_idx]) begin
                found         = 1'b1;
                gnt_idx       = cand_idx;
                gnt[cand_idx] = 1'b1;
            end
        end
    end

    // Next priority pointer: one past the winner. An explicit wrap is used
    // so that NREQ need not be a power of two.
    always_comb begin
        rr_next = (gnt_idx == LAST_REQ) ? '0 : gnt_idx + 1'b1;
    end

    assign wr    = |gnt;
    assign rd    = ren && (count != '0);
    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);

    // Storage array. It has no reset because its contents are don't-care
    // until written.
    always_ff @(posedge clk) begin
        if (wr)
            mem[waddr] <= din[int'(gnt_idx)*DW +: DW];
    end

    // Pointers, occupancy, read data and status pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            waddr      <= '0;
            raddr      <= '0;
            rr         <= '0;
            count      <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            error      <= 1'b0;
        end else begin
            dout_valid <= rd;
            error      <= ren && (count == '0);
            if (wr) begin
                waddr <= waddr + 1'b1;
                rr    <= rr_next;
            end
            if (rd) begin
                dout  <= mem[raddr];
                raddr <= raddr + 1'b1;
            end
            case ({wr, rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef FIFO_ARB_DROPCNT_EN
    // Count the cycles in which some requester waited without a grant.
    // The count saturates at 255.
    always_ff @(posedge clk) begin
        if (!rst_n)
            drop_cnt <= '0;
        else if ((|req) && !wr && (drop_cnt != 8'hFF))
            drop_cnt <= drop_cnt + 8'd1;
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed testbench for fifo_wr_arbiter. Each step is followed by
// immediate-assertion checks against hand-computed values.
module tb_fifo_wr_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int AW   = 3;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] din;
    logic [NREQ-1:0]    gnt;
    logic               ren;
    logic [DW-1:0]      dout;
    logic               dout_valid;
    logic [AW:0]        count;
    logic               full;
    logic               empty;
    logic               error;
`ifdef FIFO_ARB_DROPCNT_EN
    logic [7:0]         drop_cnt;
`endif

    fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .DEPTH(8), .AW(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .din        (din),
        .gnt        (gnt),
        .ren        (ren),
        .dout       (dout),
        .dout_valid (dout_valid),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .error      (error)
`ifdef FIFO_ARB_DROPCNT_EN
        ,
        .drop_cnt   (drop_cnt)
`endif
    );

    // scoreboard
    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  exp_b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_din(input int idx, input logic [7:0] val);
        din[idx*DW +: DW] = val;
    endtask

    initial begin
        // Reset
        rst_n = 1'b0; req = '0; ren = 1'b0; din = '0;
        tick(); tick();
        rst_n = 1'b1;
        #1;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_dout", dout, 0);
        chk("rst_dvalid", dout_valid, 0);
        chk("rst_error", error, 0);
        chk("rst_gnt", gnt, 0);

        // 1: all four request at once; grants go out in order 0,1,2,3
        req = 4'b1111;
        set_din(0, 8'h10); set_din(1, 8'h11); set_din(2, 8'h12); set_din(3, 8'h13);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t1_gnt", gnt, 32'(1 << i));
            tick();
            req[i] = 1'b0;
        end
        chk("t1_count", count, 4);
        ren = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t1_dout", dout, 32'h10 + i);
            chk("t1_dvalid", dout_valid, 1);
        end
        ren = 1'b0;
        tick();
        chk("t1_dvalid_low", dout_valid, 0);
        chk("t1_dout_hold", dout, 8'h13);
        chk("t1_empty", empty, 1);

        // 2: requester 2 alone for 9 cycles; 8 grants, then a stall
        req = 4'b0100;
        for (int k = 0; k < 8; k++) begin
            set_din(2, 8'h30 + 8'(k));
            #1;
            chk("t2_gnt", gnt, 4'b0100);
            tick();
        end
        chk("t2_full", full, 1);
        chk("t2_count", count, 8);
        #1;
        chk("t2_gnt_stall", gnt, 0);
        tick();
        chk("t2_count_hold", count, 8);
`ifdef FIFO_ARB_DROPCNT_EN
        chk("t2_drop_cnt", drop_cnt, 1);
`endif
        req = '0;

        // 3: full FIFO with a simultaneous write and read
        req = 4'b0010; set_din(1, 8'h41); ren = 1'b1;
        #1;
        chk("t3_gnt", gnt, 4'b0010);
        tick();
        chk("t3_count", count, 8);
        chk("t3_full", full, 1);
        chk("t3_dout", dout, 8'h30);
        chk("t3_dvalid", dout_valid, 1);
        req = '0;
        // drain: remaining 0x31..0x37 then 0x41
        for (int k = 1; k < 8; k++) exp_q.push_back(8'h30 + 8'(k));
        exp_q.push_back(8'h41);
        for (int k = 0; k < 8; k++) begin
            tick();
            exp_b = exp_q.pop_front();
            chk("t3_drain", dout, exp_b);
        end
        ren = 1'b0;
        tick();
        chk("t3_empty", empty, 1);

        // 4: read while empty together with a write of 0xA5 by requester 0
        ren = 1'b1; req = 4'b0001; set_din(0, 8'hA5);
        #1;
        chk("t4_gnt", gnt, 4'b0001);
        tick();
        chk("t4_error", error, 1);
        chk("t4_dout_hold", dout, 8'h41);
        chk("t4_dvalid", dout_valid, 0);
        chk("t4_count", count, 1);
        req = '0;
        tick();
        chk("t4_error_pulse", error, 0);
        chk("t4_dout", dout, 8'hA5);
        chk("t4_dvalid2", dout_valid, 1);
        chk("t4_count2", count, 0);
        ren = 1'b0;

        // 5: 20 writes interleaved with 20 reads. rr is now 1, so grants
        // rotate 1,2,3,0,... Requester i offers (k<<2)|i in cycle k.
        for (int k = 0; k <= 20; k++) begin
            if (k < 20) begin
                req = 4'b1111;
                for (int i = 0; i < 4; i++) set_din(i, 8'((k << 2) | i));
            end else begin
                req = '0;
            end
            ren = (k >= 1);
            #1;
            if (k < 20) begin
                chk("t5_gnt", gnt, 32'(1 << ((1 + k) % 4)));
                exp_q.push_back(8'((k << 2) | ((1 + k) % 4)));
            end
            tick();
            if (k >= 1) begin
                exp_b = exp_q.pop_front();
                chk("t5_dout", dout, exp_b);
                chk("t5_dvalid", dout_valid, 1);
            end
        end
        ren = 1'b0; req = '0;
        chk("t5_count", count, 0);

        // 6: reset with five entries stored
        req = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            set_din(0, 8'h70 + 8'(k));
            tick();
        end
        req = '0;
        chk("t6_count5", count, 5);
        rst_n = 1'b0; req = 4'b1111; ren = 1'b1;
        #1;
        chk("t6_gnt_in_rst", gnt, 0);
        tick();
        chk("t6_count", count, 0);
        chk("t6_empty", empty, 1);
        chk("t6_dout", dout, 0);
        chk("t6_error", error, 0);
        chk("t6_dvalid", dout_valid, 0);
        chk("t6_gnt", gnt, 0);
        rst_n = 1'b1; ren = 1'b0;
        #1;
        chk("t6_rr_reset", gnt, 4'b0001);
        tick();
        chk("t6_count_after", count, 1);
        req = '0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
